// File: rtl/trena_pkg.sv
// rtl/trena_pkg.sv - shared constants, state encodings and bit-time helper for the trena receiver
package trena_pkg;

  localparam logic [6:0] ASCII_ZERO = 7'h30;
  localparam logic [6:0] ASCII_NINE = 7'h39;
  localparam logic [6:0] ASCII_HASH = 7'h23;

  typedef enum logic [1:0] {
    E_CENTENA = 2'd0,
    E_DEZENA  = 2'd1,
    E_UNIDADE = 2'd2,
    E_HASH    = 2'd3
  } estado_quadro_t;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    START    = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    STOP1    = 3'd4,
    STOP2    = 3'd5
  } estado_rx_t;

  function automatic int ciclos_bit(input int clock_freq, input int baud);
    return (clock_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/rx_serial_7E2.sv
// rtl/rx_serial_7E2.sv - 7E2 asynchronous character receiver with input synchronizer
module rx_serial_7E2
  import trena_pkg::*;
#(
  parameter int CICLOS_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [6:0] dado,
  output logic       rx_pronto,
  output logic       par_ok,
  output logic       stop_ok
);

  localparam int W = $clog2(CICLOS_BIT + 1);
  localparam logic [W-1:0] FIM_BIT  = W'(CICLOS_BIT - 1);
  localparam logic [W-1:0] MEIO_BIT = W'(CICLOS_BIT / 2 - 1);

  estado_rx_t   estado_q, estado_d;
  logic [1:0]   sinc_q;
  logic         linha_ant_q;
  logic [W-1:0] cnt_q, cnt_d;
  logic [2:0]   nbit_q, nbit_d;
  logic [6:0]   shift_q, shift_d;
  logic         par_q, par_d;
  logic         stop1_q, stop1_d;
  logic [6:0]   dado_q, dado_d;
  logic         rx_pronto_q, rx_pronto_d;
  logic         par_ok_q, par_ok_d;
  logic         stop_ok_q, stop_ok_d;
  logic         linha;
  logic         amostra;

  assign linha = sinc_q[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc_q      <= 2'b11;
      linha_ant_q <= 1'b1;
      estado_q    <= OCIOSO;
      cnt_q       <= '0;
      nbit_q      <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      stop1_q     <= 1'b0;
      dado_q      <= '0;
      rx_pronto_q <= 1'b0;
      par_ok_q    <= 1'b0;
      stop_ok_q   <= 1'b0;
    end else begin
      sinc_q      <= {sinc_q[0], entrada_serial};
      linha_ant_q <= linha;
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      nbit_q      <= nbit_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      stop1_q     <= stop1_d;
      dado_q      <= dado_d;
      rx_pronto_q <= rx_pronto_d;
      par_ok_q    <= par_ok_d;
      stop_ok_q   <= stop_ok_d;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    cnt_d       = cnt_q + W'(1);
    nbit_d      = nbit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    stop1_d     = stop1_q;
    dado_d      = dado_q;
    par_ok_d    = par_ok_q;
    stop_ok_d   = stop_ok_q;
    rx_pronto_d = 1'b0;
    amostra     = (cnt_q == FIM_BIT);
    case (estado_q)
      // A line held low leaves linha_ant_q low, so no new start until it rises
      OCIOSO: begin
        cnt_d = '0;
        if (linha_ant_q && !linha) estado_d = START;
      end
      START: if (cnt_q == MEIO_BIT) begin
        cnt_d    = '0;
        nbit_d   = '0;
        estado_d = linha ? OCIOSO : DADOS;
      end
      DADOS: if (amostra) begin
        cnt_d   = '0;
        shift_d = {linha, shift_q[6:1]};
        nbit_d  = nbit_q + 3'd1;
        if (nbit_q == 3'd6) estado_d = PARIDADE;
      end
      PARIDADE: if (amostra) begin
        cnt_d    = '0;
        par_d    = linha;
        estado_d = STOP1;
      end
      STOP1: if (amostra) begin
        cnt_d    = '0;
        stop1_d  = linha;
        estado_d = STOP2;
      end
      STOP2: if (amostra) begin
        cnt_d       = '0;
        estado_d    = OCIOSO;
        rx_pronto_d = 1'b1;
        dado_d      = shift_q;
        par_ok_d    = ~(^{shift_q, par_q});
        stop_ok_d   = stop1_q & linha;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign dado      = dado_q;
  assign rx_pronto = rx_pronto_q;
  assign par_ok    = par_ok_q;
  assign stop_ok   = stop_ok_q;

endmodule

// File: rtl/trena_receptor_medida.sv
// rtl/trena_receptor_medida.sv - assembles "<c><d><u>#" frames from the serial line into a BCD measurement
module trena_receptor_medida
  import trena_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int CICLOS_BIT = ciclos_bit(CLOCK_FREQ, BAUD)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro_paridade,
  output logic        erro_formato,
  output logic [6:0]  db_caractere,
  output logic [3:0]  db_estado
);

  logic [6:0] rx_dado;
  logic       rx_pronto, rx_par_ok, rx_stop_ok;

  rx_serial_7E2 #(.CICLOS_BIT(CICLOS_BIT)) u_rx (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .dado           (rx_dado),
    .rx_pronto      (rx_pronto),
    .par_ok         (rx_par_ok),
    .stop_ok        (rx_stop_ok)
  );

  estado_quadro_t est_q, est_d;
  logic [3:0]  cen_q, cen_d, dez_q, dez_d, uni_q, uni_d;
  logic [11:0] medida_q, medida_d;
  logic        pronto_q, pronto_d;
  logic        ep_q, ep_d, ef_q, ef_d;
  logic [6:0]  car_q, car_d;
  logic        eh_digito, eh_hash;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      est_q    <= E_CENTENA;
      cen_q    <= '0;
      dez_q    <= '0;
      uni_q    <= '0;
      medida_q <= '0;
      pronto_q <= 1'b0;
      ep_q     <= 1'b0;
      ef_q     <= 1'b0;
      car_q    <= '0;
    end else begin
      est_q    <= est_d;
      cen_q    <= cen_d;
      dez_q    <= dez_d;
      uni_q    <= uni_d;
      medida_q <= medida_d;
      pronto_q <= pronto_d;
      ep_q     <= ep_d;
      ef_q     <= ef_d;
      car_q    <= car_d;
    end
  end

  always_comb begin
    est_d     = est_q;
    cen_d     = cen_q;
    dez_d     = dez_q;
    uni_d     = uni_q;
    medida_d  = medida_q;
    pronto_d  = 1'b0;
    ep_d      = ep_q;
    ef_d      = ef_q;
    car_d     = car_q;
    eh_digito = (rx_dado >= ASCII_ZERO) && (rx_dado <= ASCII_NINE);
    eh_hash   = (rx_dado == ASCII_HASH);
    if (rx_pronto) begin
      car_d = rx_dado;
      // Content of a character with line errors is untrusted, so only the line flags apply
      if (!rx_par_ok || !rx_stop_ok) begin
        est_d = E_CENTENA;
        if (!rx_par_ok)  ep_d = 1'b1;
        if (!rx_stop_ok) ef_d = 1'b1;
      end else if (est_q == E_HASH) begin
        est_d = E_CENTENA;
        if (eh_hash) begin
          medida_d = {cen_q, dez_q, uni_q};
          pronto_d = 1'b1;
          ep_d     = 1'b0;
          ef_d     = 1'b0;
        end else begin
          ef_d = 1'b1;
        end
      end else if (eh_digito) begin
        case (est_q)
          E_CENTENA: cen_d = rx_dado[3:0];
          E_DEZENA:  dez_d = rx_dado[3:0];
          default:   uni_d = rx_dado[3:0];
        endcase
        est_d = estado_quadro_t'(est_q + 2'd1);
      end else begin
        est_d = E_CENTENA;
        if (!eh_hash) ef_d = 1'b1;
      end
    end
  end

  assign medida        = medida_q;
  assign pronto        = pronto_q;
  assign erro_paridade = ep_q;
  assign erro_formato  = ef_q;
  assign db_caractere  = car_q;
  assign db_estado     = {2'b00, est_q};

endmodule

// File: doc/trena_receptor_medida.md
# trena_receptor_medida

Serial receiver that consumes the trena's `saida_serial` stream and rebuilds the 3-digit BCD distance measurement. It sits directly downstream of the trena, typically in a second board or the test harness. It decodes 7E2 asynchronous characters and assembles the ASCII frame `<centena><dezena><unidade>#` into a 12-bit BCD word. It also flags parity and format errors.

## Interface
- `CLOCK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: serial bit rate.
- `CICLOS_BIT`, CLOCK_FREQ/BAUD (434): clocks per bit; integer, rounded to nearest.

- `clock`: in, 1. Single system clock, rising edge.
- `reset`: in, 1. Asynchronous, active-low reset.
- `entrada_serial`: in, 1. Serial line, idle high; connects to the trena's `saida_serial`.
- `medida`: out, 12. Last valid measurement, BCD {centena, dezena, unidade}.
- `pronto`: out, 1. One-cycle pulse when `medida` is updated.
- `erro_paridade`: out, 1. Sticky; set on any character with a parity error.
- `erro_formato`: out, 1. Sticky; set on a bad character or a stop-bit error.
- `db_caractere`: out, 7. Last received character, for debug.
- `db_estado`: out, 4. Frame-assembler state, for debug.

## Operation
- Character format, LSB first: start(0), 7 data bits, even parity, 2 stop bits(1).
- `entrada_serial` passes through a 2-FF synchronizer before any use.
- RX state machine states: OCIOSO, START, DADOS, PARIDADE, STOP1, STOP2.
  - OCIOSO to START on a falling edge of the line.
  - In START, sample at CICLOS_BIT/2. If the line is high, treat it as a glitch and return to OCIOSO.
  - Each later bit is sampled CICLOS_BIT clocks after the previous sample.
  - At the STOP2 sample, emit an internal `rx_pronto` pulse with the 7-bit character, `par_ok` and `stop_ok`, then return to OCIOSO.
- Frame assembler states: E_CENTENA (0), E_DEZENA (1), E_UNIDADE (2), E_HASH (3).
  - A digit is ASCII 0x30–0x39. Store its low nibble and advance one state.
  - In E_HASH, receiving 0x23 (`#`) writes the three nibbles to `medida`, pulses `pronto`, clears both error flags and returns to E_CENTENA.
  - Parity error (par_ok=0): set `erro_paridade`, discard the partial frame, go to E_CENTENA.
  - Either stop bit low, a non-digit in states 0–2, or a non-`#` in state 3: set `erro_formato`, discard, go to E_CENTENA.
  - Exception to the previous rule: a `#` received in states 0–2 also returns to E_CENTENA; this resynchronises the receiver.
- `medida` changes only on a complete valid frame; partial or errored frames never alter it.
- Reset values: `medida`=0, `pronto`=0, both error flags 0, `db_caractere`=0, `db_estado`=0, RX in OCIOSO, assembler in E_CENTENA.
- Reset may arrive mid-character or mid-frame. It aborts immediately, and the next start bit is decoded normally.

## Timing
- Input latency: 2 cycles of synchronizer.
- `rx_pronto` is asserted at the center of STOP2, i.e. 10.5·CICLOS_BIT after the synchronized start edge.
- `medida`, `pronto`, the error flags and `db_caractere` update on the clock edge after `rx_pronto` (1 cycle).
- `pronto` is exactly one cycle wide.
- Back-to-back characters with no idle gap must be received. The falling edge of the next start bit can arrive from 0.5 bit after the STOP2 sample onward.
- A parity error and a stop-bit error in the same character set both flags.
- A line held low (break) produces one errored character. The RX then waits in OCIOSO for the line to return high before it accepts a new falling edge.

## Structure
- Shared package/include `trena_pkg` contains:
  - `ASCII_ZERO` (7'h30), `ASCII_HASH` (7'h23).
  - The assembler state encodings.
  - The CICLOS_BIT computation.
- Sub-module `rx_serial_7E2` holds the synchronizer, bit-timer counter, shift register and parity check. Its outputs are `dado[6:0]`, `rx_pronto`, `par_ok`, `stop_ok`.
- Top-level `trena_receptor_medida` holds the frame-assembler FSM and the digit/output registers.

## Test plan
- Send "123#": `medida`=12'h123, one `pronto` pulse about 1 cycle after the `#` STOP2 sample, both errors 0, `db_estado`=0.
- Send "4?5#" with bad parity on the second character: no `pronto`, `erro_paridade`=1, `medida` stays 12'h123. Then send "456#": `medida`=12'h456, `erro_paridade` clears.
- Send "1A3#": `erro_formato`=1, no `pronto`. Then send "078#": `medida`=12'h078, flag clears.
- Pulse the line low for 100 cycles (glitch): no character and no state change. Send "12#" then "999#": first is a resync with no `pronto`, second gives `medida`=12'h999.
- Assert reset during the data bits of the second character of "555#": all outputs 0 immediately. Then send "321#": `medida`=12'h321.
- Send two frames "010#" and "200#" back-to-back with no idle: two `pronto` pulses 4 characters apart; final `medida`=12'h200.
